// File: rtl/s3g_pkg.sv
// rtl/s3g_pkg.sv - shared types and sizes for the s3g transmit path
package s3g_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   localparam int S3G_MAX_PAYLOAD = 16;
   localparam int S3G_BUF_W       = 128;

   function automatic logic len_ok(input logic [7:0] len, input int max_len);
      return int'(len) <= max_len;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker; the requester that did not win last goes first on a tie
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       any,
   output logic       winner
);

   always_comb begin
      any    = |req;
      winner = (req == 2'b11) ? ~last_grant : req[1];
   end

endmodule

// File: rtl/s3g_tx_arbiter.sv
// rtl/s3g_tx_arbiter.sv - shares the s3g_tx packet transmitter between the reply path and the event reporter
module s3g_tx_arbiter
   import s3g_pkg::*;
#(
   parameter int BUSY_TIMEOUT = 1024,
   parameter int MAX_LEN      = S3G_MAX_PAYLOAD,
   parameter int CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   input  logic [7:0]           req0_len,
   input  logic [S3G_BUF_W-1:0] req0_data,
   output logic                 req0_ack,
   input  logic                 req1_valid,
   input  logic [7:0]           req1_len,
   input  logic [S3G_BUF_W-1:0] req1_data,
   output logic                 req1_ack,
   input  logic                 tx_busy,
   output logic                 tx_packet_wr,
   output logic [7:0]           tx_payload_len,
   output logic [S3G_BUF_W-1:0] tx_data,
   output logic                 grant,
   output logic                 active,
   output logic                 err_len,
   output logic                 err_timeout,
   output logic [CNT_W-1:0]     sent0,
   output logic [CNT_W-1:0]     sent1
);

   localparam int TIMER_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUSY_TIMEOUT - 1);

   state_t               state, state_nx;
   logic                 last_grant, last_grant_nx;
   logic [TIMER_W-1:0]   timer, timer_nx;
   logic                 req0_ack_nx, req1_ack_nx, tx_packet_wr_nx;
   logic [7:0]           tx_payload_len_nx;
   logic [S3G_BUF_W-1:0] tx_data_nx;
   logic                 grant_nx, active_nx, err_len_nx, err_timeout_nx;
   logic [CNT_W-1:0]     sent0_nx, sent1_nx;

   logic [1:0]           req_vec;
   logic                 any, winner;
   logic [7:0]           sel_len;
   logic [S3G_BUF_W-1:0] sel_data;

   // A requester whose ack is on the wire this cycle has not yet had the
   // chance to drop valid, so it must not be arbitrated again.
   assign req_vec  = {req1_valid & ~req1_ack, req0_valid & ~req0_ack};
   assign sel_len  = winner ? req1_len  : req0_len;
   assign sel_data = winner ? req1_data : req0_data;

   rr_arb2 u_rr_arb2 (
      .req        (req_vec),
      .last_grant (last_grant),
      .any        (any),
      .winner     (winner)
   );

   always_comb begin
      state_nx          = state;
      last_grant_nx     = last_grant;
      timer_nx          = timer;
      req0_ack_nx       = 1'b0;
      req1_ack_nx       = 1'b0;
      tx_packet_wr_nx   = 1'b0;
      err_len_nx        = 1'b0;
      err_timeout_nx    = 1'b0;
      tx_payload_len_nx = tx_payload_len;
      tx_data_nx        = tx_data;
      grant_nx          = grant;
      sent0_nx          = sent0;
      sent1_nx          = sent1;

      case (state)
         IDLE: begin
            if (!tx_busy && any) begin
               last_grant_nx = winner;
               req0_ack_nx   = ~winner;
               req1_ack_nx   = winner;
               if (len_ok(sel_len, MAX_LEN)) begin
                  tx_packet_wr_nx   = 1'b1;
                  tx_payload_len_nx = sel_len;
                  tx_data_nx        = sel_data;
                  grant_nx          = winner;
                  timer_nx          = '0;
                  state_nx          = WAIT_BUSY;
               end else begin
                  err_len_nx = 1'b1;
               end
            end
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_nx = WAIT_DONE;
            end else if (timer == TIMER_LAST) begin
               err_timeout_nx = 1'b1;
               state_nx       = IDLE;
            end else begin
               timer_nx = timer + TIMER_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               if (grant) sent1_nx = sent1 + CNT_W'(1);
               else       sent0_nx = sent0 + CNT_W'(1);
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase

      active_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         last_grant     <= 1'b1;
         timer          <= '0;
         req0_ack       <= 1'b0;
         req1_ack       <= 1'b0;
         tx_packet_wr   <= 1'b0;
         tx_payload_len <= '0;
         tx_data        <= '0;
         grant          <= 1'b0;
         active         <= 1'b0;
         err_len        <= 1'b0;
         err_timeout    <= 1'b0;
         sent0          <= '0;
         sent1          <= '0;
      end else begin
         state          <= state_nx;
         last_grant     <= last_grant_nx;
         timer          <= timer_nx;
         req0_ack       <= req0_ack_nx;
         req1_ack       <= req1_ack_nx;
         tx_packet_wr   <= tx_packet_wr_nx;
         tx_payload_len <= tx_payload_len_nx;
         tx_data        <= tx_data_nx;
         grant          <= grant_nx;
         active         <= active_nx;
         err_len        <= err_len_nx;
         err_timeout    <= err_timeout_nx;
         sent0          <= sent0_nx;
         sent1          <= sent1_nx;
      end
   end

endmodule

// File: tb/tb_s3g_tx_arbiter.sv
// tb/tb_s3g_tx_arbiter.sv - directed vector table plus multi-cycle sequences for s3g_tx_arbiter
module tb_s3g_tx_arbiter;

   localparam logic [127:0] D0 = {104'h0, 24'h332211};
   localparam logic [127:0] D1 = 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0]   req0_len = 8'd0, req1_len = 8'd0;
   logic [127:0] req0_data = D0, req1_data = D1;
   logic         req0_ack, req1_ack;
   logic         tx_busy = 1'b0;
   logic         tx_packet_wr;
   logic [7:0]   tx_payload_len;
   logic [127:0] tx_data;
   logic         grant, active, err_len, err_timeout;
   logic [15:0]  sent0, sent1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   s3g_tx_arbiter #(.BUSY_TIMEOUT(8), .MAX_LEN(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_len(req0_len), .req0_data(req0_data), .req0_ack(req0_ack),
      .req1_valid(req1_valid), .req1_len(req1_len), .req1_data(req1_data), .req1_ack(req1_ack),
      .tx_busy(tx_busy), .tx_packet_wr(tx_packet_wr), .tx_payload_len(tx_payload_len),
      .tx_data(tx_data), .grant(grant), .active(active), .err_len(err_len),
      .err_timeout(err_timeout), .sent0(sent0), .sent1(sent1)
   );

   // {wr, ack0, ack1, grant, active, err_len, err_timeout, sent0, sent1}
   typedef struct {
      logic        rst, v0, v1, busy;
      logic [7:0]  l0, l1;
      logic [38:0] exp_obs;
      logic [7:0]  exp_len;
      logic        exp_src;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [38:0] obs();
      return {tx_packet_wr, req0_ack, req1_ack, grant, active, err_len, err_timeout, sent0, sent1};
   endfunction

   task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
      end
   endtask

   task automatic add(input int n, input logic r, input logic v0, input logic [7:0] l0,
                      input logic v1, input logic [7:0] l1, input logic b, input logic [6:0] f,
                      input int s0, input int s1, input logic [7:0] xl, input logic xs);
      vec_t v;
      v.rst = r; v.v0 = v0; v.l0 = l0; v.v1 = v1; v.l1 = l1; v.busy = b;
      v.exp_obs = {f, s0[15:0], s1[15:0]};
      v.exp_len = xl; v.exp_src = xs;
      repeat (n) vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int  rem0, rem1, n_wr, bs, cnt;
      logic exp_g, busy_seen, got;

      // flags: wr ack0 ack1 grant active err_len err_timeout
      add(1,  1, 0, 0, 0, 0,  0, 7'b0000000, 0, 0, 0, 0);
      add(1,  0, 0, 0, 0, 0,  0, 7'b0000000, 0, 0, 0, 0);
      add(1,  0, 1, 3, 0, 0,  0, 7'b1100100, 0, 0, 3, 0);
      add(2,  0, 0, 0, 0, 0,  0, 7'b0000100, 0, 0, 0, 0);
      add(10, 0, 0, 0, 0, 0,  1, 7'b0000100, 0, 0, 0, 0);
      add(1,  0, 0, 0, 0, 0,  0, 7'b0000000, 1, 0, 0, 0);
      add(1,  0, 0, 0, 1, 17, 0, 7'b0010010, 1, 0, 0, 0);
      add(1,  0, 0, 0, 0, 0,  0, 7'b0000000, 1, 0, 0, 0);
      add(2,  0, 1, 2, 0, 0,  1, 7'b0000000, 1, 0, 0, 0);
      add(1,  0, 1, 2, 0, 0,  0, 7'b1100100, 1, 0, 2, 0);
      add(1,  0, 0, 0, 0, 0,  0, 7'b0000100, 1, 0, 0, 0);
      add(1,  0, 0, 0, 0, 0,  1, 7'b0000100, 1, 0, 0, 0);
      add(1,  0, 0, 0, 0, 0,  0, 7'b0000000, 2, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst;
         req0_valid = vecs[i].v0; req0_len = vecs[i].l0;
         req1_valid = vecs[i].v1; req1_len = vecs[i].l1;
         tx_busy = vecs[i].busy;
         tick();
         chk("vec", i, 128'(obs()), 128'(vecs[i].exp_obs));
         if (vecs[i].exp_obs[38]) begin
            chk("vec_len", i, 128'(tx_payload_len), 128'(vecs[i].exp_len));
            chk("vec_data", i, tx_data, vecs[i].exp_src ? D1 : D0);
         end
      end

      // round-robin: both requesters stream 4 packets from reset
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; tx_busy = 1'b0;
      tick();
      rst = 1'b0;
      req0_len = 8'd4; req1_len = 8'd5;
      rem0 = 4; rem1 = 4; n_wr = 0; bs = -100; exp_g = 1'b0; busy_seen = 1'b0;
      for (int k = 0; k < 300; k++) begin
         req0_valid = (rem0 > 0);
         req1_valid = (rem1 > 0);
         tx_busy = (k >= bs) && (k < bs + 3);
         if (tx_busy) busy_seen = 1'b1;
         tick();
         if (req0_ack) rem0--;
         if (req1_ack) rem1--;
         if (tx_packet_wr) begin
            chk("rr_grant", n_wr, 128'(grant), 128'(exp_g));
            chk("rr_len", n_wr, 128'(tx_payload_len), exp_g ? 128'd5 : 128'd4);
            if (n_wr > 0) chk("rr_busy_between", n_wr, 128'(busy_seen), 128'd1);
            busy_seen = 1'b0;
            exp_g = ~exp_g;
            n_wr++;
            bs = k + 3;
         end
         if (rem0 == 0 && rem1 == 0 && !active) break;
      end
      req0_valid = 1'b0; req1_valid = 1'b0; tx_busy = 1'b0;
      chk("rr_count", 0, 128'(n_wr), 128'd8);
      chk("rr_sent0", 0, 128'(sent0), 128'd4);
      chk("rr_sent1", 0, 128'(sent1), 128'd4);

      // tx_busy never rises: timeout 8 cycles after the strobe
      req0_valid = 1'b1; req0_len = 8'd1; got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         tick();
         if (req0_ack) req0_valid = 1'b0;
         if (tx_packet_wr) got = 1'b1;
      end
      chk("to_strobe", 0, 128'(got), 128'd1);
      cnt = 0; got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         tick();
         cnt++;
         if (err_timeout) got = 1'b1;
      end
      chk("to_delay", 0, 128'(cnt), 128'd8);
      chk("to_idle", 0, 128'(active), 128'd0);
      chk("to_sent0", 0, 128'(sent0), 128'd4);

      req1_valid = 1'b1; req1_len = 8'd2; got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         tick();
         if (req1_ack) req1_valid = 1'b0;
         if (tx_packet_wr) got = 1'b1;
      end
      chk("to_next_accept", 0, 128'({got, grant, tx_payload_len}), 128'({1'b1, 1'b1, 8'd2}));
      tx_busy = 1'b1;
      tick();
      tick();
      tx_busy = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         tick();
         if (!active) got = 1'b1;
      end
      chk("to_next_sent1", 0, 128'(sent1), 128'd5);

      // reset in WAIT_DONE with req1 pending
      req0_valid = 1'b1; req0_len = 8'd3; got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         tick();
         if (req0_ack) req0_valid = 1'b0;
         if (tx_packet_wr) got = 1'b1;
      end
      tx_busy = 1'b1;
      req1_valid = 1'b1; req1_len = 8'd6;
      tick();
      tick();
      chk("rst_pre_active", 0, 128'({active, req1_ack}), 128'({1'b1, 1'b0}));
      rst = 1'b1;
      tick();
      chk("rst_outputs", 0, 128'({obs(), tx_payload_len}), 128'd0);
      chk("rst_data", 0, tx_data, 128'd0);
      rst = 1'b0; tx_busy = 1'b0;
      tick();
      chk("rst_regrant", 0, 128'({tx_packet_wr, req1_ack, grant, active, tx_payload_len}),
          128'({4'b1111, 8'd6}));
      chk("rst_regrant_data", 0, tx_data, D1);
      req1_valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
